// File: rtl/gpio_mmio_pkg.sv
// Shared constants for the memory-mapped GPIO peripheral: register offsets
// (word index within the 16-byte window) and the default base address.
package gpio_mmio_pkg;

   localparam logic [1:0]  GPIO_OFF_IN   = 2'd0;
   localparam logic [1:0]  GPIO_OFF_OUT  = 2'd1;
   localparam logic [1:0]  GPIO_OFF_EDGE = 2'd2;
   localparam logic [1:0]  GPIO_OFF_IE   = 2'd3;

   localparam logic [31:0] GPIO_BASE_DEFAULT = 32'h1001_0000;

endpackage : gpio_mmio_pkg

// File: rtl/gpio_sync_edge.sv
// Three-stage synchronizer for a vector of asynchronous pins. The first two
// stages resolve metastability; the third stage delays the synchronized value
// one more cycle so a rising edge can be detected as s2 & ~s3.
module gpio_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pinIn,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] s1_r;
   logic [WIDTH-1:0] s2_r;
   logic [WIDTH-1:0] s3_r;

   // Shift the pin values through the three stages; active-low sync reset clears all.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_r <= {WIDTH{1'b0}};
         s2_r <= {WIDTH{1'b0}};
         s3_r <= {WIDTH{1'b0}};
      end else begin
         s1_r <= pinIn;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign sync = s2_r;
   assign rise = s2_r & ~s3_r;

endmodule : gpio_sync_edge

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO peripheral: synchronized input port, registered output
// port, sticky rising-edge flags (write-1-to-clear) and a level interrupt.
// Read data is combinational so the core captures it in the address cycle.
module gpio_mmio
   import gpio_mmio_pkg::*;
#(
   parameter int          GPIO_WIDTH = 8,
   parameter logic [31:0] GPIO_BASE  = GPIO_BASE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           Address,
   input  logic [31:0]           WriteData,
   input  logic                  MemWrite,
   output logic [31:0]           ReadData,
   output logic                  hit,
   input  logic [GPIO_WIDTH-1:0] gpio_port_in,
   output logic [GPIO_WIDTH-1:0] gpio_port_out,
   output logic                  irq
);

   logic [GPIO_WIDTH-1:0] outReg_r;
   logic [GPIO_WIDTH-1:0] edgeReg_r;
   logic [GPIO_WIDTH-1:0] ieReg_r;

   logic [GPIO_WIDTH-1:0] sync_s;
   logic [GPIO_WIDTH-1:0] rise_s;
   logic [GPIO_WIDTH-1:0] clrMask_s;
   logic [1:0]            offset_s;
   logic                  wrOut_s;
   logic                  wrEdge_s;
   logic                  wrIe_s;
   logic [31:0]           readData_s;

   // Byte-address bits and store bits above GPIO_WIDTH are deliberately ignored.
   logic                  unusedBits_s;
   assign unusedBits_s = ^{Address[1:0], WriteData};

   gpio_sync_edge #(
      .WIDTH (GPIO_WIDTH)
   ) uSyncEdge (
      .clk   (clk),
      .reset (reset),
      .pinIn (gpio_port_in),
      .sync  (sync_s),
      .rise  (rise_s)
   );

   assign hit      = (Address[31:4] == GPIO_BASE[31:4]);
   assign offset_s = Address[3:2];

   // Decode a store into per-register write strobes and the edge clear mask.
   always_comb begin
      wrOut_s   = 1'b0;
      wrEdge_s  = 1'b0;
      wrIe_s    = 1'b0;
      clrMask_s = {GPIO_WIDTH{1'b0}};
      if (MemWrite && hit) begin
         case (offset_s)
            GPIO_OFF_OUT:  wrOut_s  = 1'b1;
            GPIO_OFF_EDGE: wrEdge_s = 1'b1;
            GPIO_OFF_IE:   wrIe_s   = 1'b1;
            default:       wrOut_s  = 1'b0;
         endcase
      end else begin
         wrOut_s = 1'b0;
      end
      if (wrEdge_s) begin
         clrMask_s = WriteData[GPIO_WIDTH-1:0];
      end else begin
         clrMask_s = {GPIO_WIDTH{1'b0}};
      end
   end

   // Register updates; a new rising edge overrides a same-cycle W1C on that bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         outReg_r  <= {GPIO_WIDTH{1'b0}};
         edgeReg_r <= {GPIO_WIDTH{1'b0}};
         ieReg_r   <= {GPIO_WIDTH{1'b0}};
      end else begin
         if (wrOut_s) begin
            outReg_r <= WriteData[GPIO_WIDTH-1:0];
         end else begin
            outReg_r <= outReg_r;
         end
         if (wrIe_s) begin
            ieReg_r <= WriteData[GPIO_WIDTH-1:0];
         end else begin
            ieReg_r <= ieReg_r;
         end
         edgeReg_r <= (edgeReg_r & ~clrMask_s) | rise_s;
      end
   end

   // Side-effect-free read mux, zero-extended, zero on a decode miss.
   always_comb begin
      readData_s = 32'd0;
      if (hit) begin
         case (offset_s)
            GPIO_OFF_IN:   readData_s[GPIO_WIDTH-1:0] = sync_s;
            GPIO_OFF_OUT:  readData_s[GPIO_WIDTH-1:0] = outReg_r;
            GPIO_OFF_EDGE: readData_s[GPIO_WIDTH-1:0] = edgeReg_r;
            GPIO_OFF_IE:   readData_s[GPIO_WIDTH-1:0] = ieReg_r;
            default:       readData_s = 32'd0;
         endcase
      end else begin
         readData_s = 32'd0;
      end
   end

   assign ReadData      = readData_s;
   assign gpio_port_out = outReg_r;
   assign irq           = |(edgeReg_r & ieReg_r);

endmodule : gpio_mmio

// File: tb/tb_gpio_mmio.sv
// Directed self-checking bench for gpio_mmio. Inputs change 1 ns after a
// rising edge; outputs are sampled before the next rising edge.
module tb_gpio_mmio;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        hit;
   logic [7:0]  gpio_port_in;
   logic [7:0]  gpio_port_out;
   logic        irq;

   int checks = 0;
   int errors = 0;

   gpio_mmio #(
      .GPIO_WIDTH (8),
      .GPIO_BASE  (BASE)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .Address       (Address),
      .WriteData     (WriteData),
      .MemWrite      (MemWrite),
      .ReadData      (ReadData),
      .hit           (hit),
      .gpio_port_in  (gpio_port_in),
      .gpio_port_out (gpio_port_out),
      .irq           (irq)
   );

   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
      Address   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
      WriteData = 32'd0;
   endtask

   task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
      Address = addr;
      #1;
      data = ReadData;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b0; gpio_port_in = 8'hFF;
      Address = BASE + 32'd4; WriteData = 32'hFFFF_FFFF; MemWrite = 1'b1;
      tick(); tick();
      checks++; if (gpio_port_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", gpio_port_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      for (int i = 0; i < 4; i++) begin
         readReg(BASE + 32'(i * 4), rd);
         checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_read%0d got %h exp 0", i, rd); end
      end
      MemWrite = 1'b0; WriteData = 32'd0; gpio_port_in = 8'h00;
      tick();
      reset = 1'b1;
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_out_rw();
      logic [31:0] rd;
      doWrite(BASE + 32'd4, 32'hFFFF_FFA5);
      checks++; if (gpio_port_out !== 8'hA5) begin errors++; $display("FAIL out_pins got %h exp a5", gpio_port_out); end
      readReg(BASE + 32'd4, rd);
      checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL out_read got %h exp 000000a5", rd); end
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL out_hit got %b exp 1", hit); end
      doWrite(BASE + 32'd5, 32'h0000_005A);
      checks++; if (gpio_port_out !== 8'h5A) begin errors++; $display("FAIL alias_pins got %h exp 5a", gpio_port_out); end
      readReg(BASE + 32'd7, rd);
      checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL alias_read got %h exp 0000005a", rd); end
      doWrite(BASE + 32'd12, 32'h0000_0004);
      readReg(BASE + 32'd12, rd);
      checks++; if (rd !== 32'h0000_0004) begin errors++; $display("FAIL ie_read got %h exp 00000004", rd); end
      doWrite(BASE, 32'h0000_00FF);
      readReg(BASE, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL in_ro got %h exp 0", rd); end
   endtask

   task automatic test_input_latency();
      logic [31:0] rd;
      gpio_port_in = 8'h3C;
      tick();
      readReg(BASE, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL lat_in_k got %h exp 0", rd); end
      tick();
      readReg(BASE, rd);
      checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL lat_in_k1 got %h exp 3c", rd); end
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL lat_edge_k1 got %h exp 0", rd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lat_irq_k1 got %b exp 0", irq); end
      tick();
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL lat_edge_k2 got %h exp 3c", rd); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lat_irq_k2 got %b exp 1", irq); end
   endtask

   task automatic test_w1c();
      logic [31:0] rd;
      doWrite(BASE + 32'd8, 32'h0000_000C);
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_0030) begin errors++; $display("FAIL w1c got %h exp 30", rd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
      doWrite(BASE + 32'd8, 32'h0000_0000);
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_0030) begin errors++; $display("FAIL w0_noop got %h exp 30", rd); end
      gpio_port_in = 8'h3D;
      tick(); tick();
      doWrite(BASE + 32'd8, 32'h0000_0011);
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_0021) begin errors++; $display("FAIL collide got %h exp 21", rd); end
      doWrite(BASE + 32'd8, 32'h0000_0001);
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_0020) begin errors++; $display("FAIL clr_bit0 got %h exp 20", rd); end
   endtask

   task automatic test_decode_miss();
      Address = BASE + 32'd16; WriteData = 32'h0000_00FF; MemWrite = 1'b1;
      #1;
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", hit); end
      checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL miss_read got %h exp 0", ReadData); end
      tick();
      MemWrite = 1'b0;
      checks++; if (gpio_port_out !== 8'h5A) begin errors++; $display("FAIL miss_out got %h exp 5a", gpio_port_out); end
      Address = BASE - 32'd4; MemWrite = 1'b1;
      #1;
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_below got %b exp 0", hit); end
      tick();
      MemWrite = 1'b0; WriteData = 32'd0;
      checks++; if (gpio_port_out !== 8'h5A) begin errors++; $display("FAIL miss_below_out got %h exp 5a", gpio_port_out); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      gpio_port_in = 8'h00;
      tick(); tick(); tick();
      doWrite(BASE + 32'd8, 32'h0000_00FF);
      doWrite(BASE + 32'd12, 32'h0000_00FF);
      gpio_port_in = 8'hFF;
      tick(); tick(); tick();
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL pre_edge got %h exp ff", rd); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_irq got %b exp 1", irq); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
      checks++; if (gpio_port_out !== 8'h00) begin errors++; $display("FAIL rst_out got %h exp 00", gpio_port_out); end
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_edge got %h exp 0", rd); end
      readReg(BASE + 32'd12, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_ie got %h exp 0", rd); end
      tick(); tick();
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL recap_early got %h exp 0", rd); end
      tick();
      readReg(BASE + 32'd8, rd);
      checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL recap_third got %h exp ff", rd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL recap_irq got %b exp 0", irq); end
   endtask

   initial begin
      reset = 1'b0; Address = 32'd0; WriteData = 32'd0; MemWrite = 1'b0;
      gpio_port_in = 8'h00;
      test_reset();
      test_out_rw();
      test_input_latency();
      test_w1c();
      test_decode_miss();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_gpio_mmio
